game_flow_ctrl: RTL and testbench

- Top-level game sequencer in front of the game logic cluster (enemy/base/missile/fire control).
- Runs the title → countdown → play → game-over loop.
- Holds the game logic in reset outside play and gates the player's fire click into the missile path.
- Tracks surviving bases, difficulty level derived from killcount, final score and high score.

---
 rtl/game_flow_ctrl.sv | 140 ++++++++++++++
 tb/tb_game_flow_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game sequencer: title -> countdown -> play -> game-over loop. It gates the game-logic
// reset and the fire click, and tracks bases, difficulty level, final score and high score.
module game_flow_ctrl #(
    parameter int OUT_WIDTH         = 8,
    parameter int START_HOLD_CYCLES = 65_000_000,
    parameter int OVER_HOLD_CYCLES  = 130_000_000,
    parameter int LEVEL_STEP        = 10,
    parameter int MAX_LEVEL         = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 click,
    input  logic                 base1_nuked,
    input  logic                 base2_nuked,
    input  logic                 base3_nuked,
    input  logic [OUT_WIDTH-1:0] killcount,
    output logic                 game_rst_n,
    output logic                 click_game,
    output logic [1:0]           state,
    output logic [2:0]           level,
    output logic [1:0]           bases_left,
    output logic [OUT_WIDTH-1:0] final_score,
    output logic [OUT_WIDTH-1:0] high_score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_PLAY  = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    localparam int HOLD_MAX = (START_HOLD_CYCLES > OVER_HOLD_CYCLES) ? START_HOLD_CYCLES
                                                                     : OVER_HOLD_CYCLES;
    localparam int CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int TW       = OUT_WIDTH + 1;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    STEP       = TW'(LEVEL_STEP);
    localparam logic [2:0]       LVL_MAX    = 3'(MAX_LEVEL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       lost_q, lost_d;
    logic [2:0]       level_q, level_d;
    logic [TW-1:0]    thr_q, thr_d;
    logic             click_q;
    logic             rise;
    logic             game_end;
    logic [1:0]       lost_cnt;

    assign rise     = click & ~click_q;
    assign lost_cnt = 2'({1'b0, lost_q[0]} + {1'b0, lost_q[1]} + {1'b0, lost_q[2]});
    assign game_end = (state_q == S_PLAY) && (state_d == S_OVER);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lost_d  = lost_q;
        level_d = level_q;
        thr_d   = thr_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
                    lost_d  = '0;
                    level_d = '0;
                    thr_d   = STEP;
                end
            end
            S_COUNT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == START_LAST)
                    state_d = S_PLAY;
            end
            S_PLAY: begin
                lost_d = lost_q | {base3_nuked, base2_nuked, base1_nuked};
                // One level step per cycle; a big killcount jump catches up over cycles.
                if (({1'b0, killcount} >= thr_q) && (level_q < LVL_MAX)) begin
                    level_d = level_q + 3'd1;
                    thr_d   = thr_q + STEP;
                end
                if (lost_d == 3'b111) begin
                    state_d = S_OVER;
                    cnt_d   = '0;
                end
            end
            S_OVER: begin
                // Counter parks on its last value, which is what unlocks the restart.
                if (cnt_q != OVER_LAST)
                    cnt_d = cnt_q + 1'b1;
                else if (rise) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
                    lost_d  = '0;
                    level_d = '0;
                    thr_d   = STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lost_q      <= '0;
            level_q     <= '0;
            thr_q       <= STEP;
            click_q     <= 1'b0;
            game_rst_n  <= 1'b0;
            click_game  <= 1'b0;
            bases_left  <= 2'd3;
            final_score <= '0;
            high_score  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lost_q     <= lost_d;
            level_q    <= level_d;
            thr_q      <= thr_d;
            click_q    <= click;
            game_rst_n <= (state_d == S_PLAY);
            click_game <= (state_q == S_PLAY) && rise;
            bases_left <= 2'd3 - lost_cnt;
            if (game_end) begin
                final_score <= killcount;
                if (killcount > high_score)
                    high_score <= killcount;
            end
        end
    end

    assign state = state_q;
    assign level = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor compares them and checks every click_game pulse against its queue.
module tb_game_flow_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, click, b1, b2, b3;
    logic [W-1:0] kc;
    logic         game_rst_n, click_game;
    logic [1:0]   state, bases_left;
    logic [2:0]   level;
    logic [W-1:0] final_score, high_score;

    game_flow_ctrl #(
        .OUT_WIDTH(W), .START_HOLD_CYCLES(4), .OVER_HOLD_CYCLES(3),
        .LEVEL_STEP(2), .MAX_LEVEL(3)
    ) dut (
        .clk(clk), .rst(rst), .click(click),
        .base1_nuked(b1), .base2_nuked(b2), .base3_nuked(b3),
        .killcount(kc), .game_rst_n(game_rst_n), .click_game(click_game),
        .state(state), .level(level), .bases_left(bases_left),
        .final_score(final_score), .high_score(high_score)
    );

    always #5 clk = ~clk;

    localparam int ST = 0, GRN = 1, CG = 2, LVL = 3, BL = 4, FS = 5, HS = 6;

    typedef struct { int cyc; int id; int val; } exp_t;
    exp_t eq[$];
    int   pq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fld(int id);
        case (id)
            ST:      return int'(state);
            GRN:     return int'(game_rst_n);
            CG:      return int'(click_game);
            LVL:     return int'(level);
            BL:      return int'(bases_left);
            FS:      return int'(final_score);
            default: return int'(high_score);
        endcase
    endfunction

    function automatic string fname(int id);
        case (id)
            ST:      return "state";
            GRN:     return "game_rst_n";
            CG:      return "click_game";
            LVL:     return "level";
            BL:      return "bases_left";
            FS:      return "final_score";
            default: return "high_score";
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = eq.size() - 1; i >= 0; i--) begin
            if (eq[i].cyc <= cyc) begin
                n_cmp++;
                if (eq[i].cyc < cyc) begin
                    n_fail++;
                    $display("FAIL stale %s expectation for cyc %0d (now %0d)",
                             fname(eq[i].id), eq[i].cyc, cyc);
                end else if (fld(eq[i].id) != eq[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%0d want=%0d",
                             fname(eq[i].id), cyc, fld(eq[i].id), eq[i].val);
                end
                eq.delete(i);
            end
        end
        if (click_game) begin
            n_cmp++;
            if (pq.size() > 0 && pq[0] == cyc) void'(pq.pop_front());
            else begin
                n_fail++;
                $display("FAIL click_game pulse cyc=%0d got=1 want=0", cyc);
            end
        end
        while (pq.size() > 0 && pq[0] <= cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL click_game missing cyc=%0d got=0 want=1", pq[0]);
            void'(pq.pop_front());
        end
    end

    task automatic exp_at(int dc, int id, int val);
        exp_t e;
        e.cyc = cyc + dc; e.id = id; e.val = val;
        eq.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b0; click = 1'b0; b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; kc = '0;
        tick(2);
        exp_at(0, ST, 0); exp_at(0, GRN, 0); exp_at(0, CG, 0); exp_at(0, LVL, 0);
        exp_at(0, BL, 3); exp_at(0, FS, 0); exp_at(0, HS, 0);
        rst = 1'b1;
        tick(10);
        exp_at(0, ST, 0); exp_at(0, GRN, 0); exp_at(0, BL, 3);

        // Start: one rise, then a countdown click that must be ignored.
        click = 1'b1; exp_at(1, ST, 1); exp_at(1, GRN, 0);
        tick(1); click = 1'b0;
        tick(1); click = 1'b1;
        tick(1); click = 1'b0;
        exp_at(1, ST, 1); exp_at(2, ST, 2); exp_at(2, GRN, 1);
        tick(2);

        // Held button in PLAY: exactly one pulse.
        click = 1'b1; pq.push_back(cyc + 1);
        tick(5); click = 1'b0;
        tick(1); exp_at(0, CG, 0);

        // Level catch-up and saturation.
        kc = 8'd7;
        exp_at(1, LVL, 1); exp_at(2, LVL, 2); exp_at(3, LVL, 3); exp_at(5, LVL, 3);
        tick(5);
        kc = 8'd9; exp_at(2, LVL, 3);
        tick(3);

        // Bases; last two fall together with a simultaneous click.
        b2 = 1'b1; exp_at(2, BL, 2); exp_at(2, ST, 2);
        tick(1); b2 = 1'b0;
        tick(2);
        kc = 8'd5; b1 = 1'b1; b3 = 1'b1; click = 1'b1; pq.push_back(cyc + 1);
        exp_at(1, ST, 3); exp_at(1, FS, 5); exp_at(1, HS, 5); exp_at(1, GRN, 0);
        exp_at(2, BL, 0);
        tick(1);
        b1 = 1'b0; b3 = 1'b0; click = 1'b0; kc = '0;
        tick(1);
        click = 1'b1;
        tick(1); click = 1'b0;
        exp_at(0, ST, 3);
        tick(1);
        click = 1'b1;
        exp_at(1, ST, 1); exp_at(1, LVL, 0); exp_at(1, GRN, 0); exp_at(1, FS, 5);
        exp_at(2, BL, 3);
        tick(1); click = 1'b0;
        exp_at(4, ST, 2);
        tick(4);

        // Second game ends lower: high score kept.
        kc = 8'd3; b1 = 1'b1; b2 = 1'b1; b3 = 1'b1;
        exp_at(1, ST, 3); exp_at(1, FS, 3); exp_at(1, HS, 5);
        tick(1);
        b1 = 1'b0; b2 = 1'b0; b3 = 1'b0; kc = '0;
        tick(2);
        click = 1'b1;
        tick(1); click = 1'b0;
        exp_at(4, ST, 2);
        tick(4);

        // Third game, then reset mid-play with a coincident click.
        kc = 8'd4; b1 = 1'b1;
        exp_at(3, LVL, 2); exp_at(3, BL, 2);
        tick(1); b1 = 1'b0;
        tick(2);
        rst = 1'b0; click = 1'b1;
        exp_at(1, ST, 0); exp_at(1, HS, 0); exp_at(1, FS, 0); exp_at(1, GRN, 0);
        exp_at(1, CG, 0); exp_at(1, LVL, 0); exp_at(1, BL, 3);
        tick(1);
        rst = 1'b1; click = 1'b0; kc = '0;
        tick(3);
        exp_at(0, ST, 0); exp_at(0, GRN, 0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
